if_stage_fetch: RTL and testbench

IF_STAGE_FETCH -- requirements
Module: if_stage_fetch

---
 rtl/if_stage_fetch.sv | 139 +++++++++++++
 tb/tb_if_stage_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Instruction fetch stage: drives the instruction-memory handshake and the IF/ID register inputs.
// Define IF_EXCEPTION_EN to honour exception_req as the highest-priority redirect to EXC_VECTOR.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_plus_4,
    output logic [31:0] IR,
    output logic        IF_ID_flush
);

`ifdef IF_EXCEPTION_EN
    localparam logic EXC_EN = 1'b1;
`else
    localparam logic EXC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] drop_addr, drop_addr_next;
    logic [31:0] skid_pc4, skid_pc4_next, skid_ir, skid_ir_next;
    logic [31:0] last_pc4, last_pc4_next, last_ir, last_ir_next;

    logic        exc_active;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        xfer;

    assign exc_active = exception_req & EXC_EN;
    assign redirect   = exc_active | branch_taken | jump;
    assign redirect_target = exc_active   ? EXC_VECTOR :
                             branch_taken ? branch_target : jump_target;

    // DROP keeps presenting the abandoned address until its response is swallowed.
    assign imem_req  = !reset && (state != HOLD);
    assign imem_addr = (state == DROP) ? drop_addr : pc;
    assign xfer      = imem_req && imem_ready;

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        drop_addr_next = drop_addr;
        skid_pc4_next  = skid_pc4;
        skid_ir_next   = skid_ir;
        last_pc4_next  = last_pc4;
        last_ir_next   = last_ir;
        PC_plus_4      = 32'h0;
        IR             = 32'h0;
        IF_ID_flush    = 1'b1;

        if (!reset) begin
            if (redirect) begin
                pc_next       = redirect_target;
                skid_pc4_next = 32'h0;
                skid_ir_next  = 32'h0;
                if (imem_req && !imem_ready) begin
                    if (state != DROP)
                        drop_addr_next = pc;
                    state_next = DROP;
                end else begin
                    state_next = FETCH;
                end
            end else begin
                if (stall) begin
                    PC_plus_4   = last_pc4;
                    IR          = last_ir;
                    IF_ID_flush = 1'b0;
                end
                unique case (state)
                    FETCH: begin
                        if (xfer && stall) begin
                            skid_pc4_next = pc + 32'd4;
                            skid_ir_next  = imem_rdata;
                            state_next    = HOLD;
                        end else if (xfer) begin
                            PC_plus_4     = pc + 32'd4;
                            IR            = imem_rdata;
                            IF_ID_flush   = 1'b0;
                            pc_next       = pc + 32'd4;
                            last_pc4_next = pc + 32'd4;
                            last_ir_next  = imem_rdata;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            PC_plus_4     = skid_pc4;
                            IR            = skid_ir;
                            IF_ID_flush   = 1'b0;
                            pc_next       = skid_pc4;
                            last_pc4_next = skid_pc4;
                            last_ir_next  = skid_ir;
                            state_next    = FETCH;
                        end
                    end
                    DROP: begin
                        if (xfer)
                            state_next = FETCH;
                    end
                    default: state_next = FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            skid_pc4  <= 32'h0;
            skid_ir   <= 32'h0;
            last_pc4  <= 32'h0;
            last_ir   <= 32'h0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            drop_addr <= drop_addr_next;
            skid_pc4  <= skid_pc4_next;
            skid_ir   <= skid_ir_next;
            last_pc4  <= last_pc4_next;
            last_ir   <= last_ir_next;
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboard bench for if_stage_fetch: a stream-level fetch model predicts every cycle's outputs.
module tb_if_stage_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0004;

`ifdef IF_EXCEPTION_EN
    localparam bit EXC_ON = 1'b1;
`else
    localparam bit EXC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, exception_req, imem_ready;
    logic [31:0] branch_target, jump_target;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC_plus_4, IR;
    logic        IF_ID_flush;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0001;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    if_stage_fetch #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exception_req(exception_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .PC_plus_4(PC_plus_4), .IR(IR), .IF_ID_flush(IF_ID_flush)
    );

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] ir;
        logic        flush;
        logic        req;
        logic [31:0] addr;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Stream-level model: next pc to deliver, an instruction waiting behind a stall,
    // and a request whose answer belongs to an abandoned path.
    logic [31:0] m_pc, m_stale_addr, m_last_pc4, m_last_ir;
    bit          m_buf, m_stale;

    task automatic cycle(input bit r, input bit st, input bit br, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt, input bit ex, input bit rdy,
                         input string tag);
        exp_t        e;
        logic [31:0] cur, tgt;
        bit          redir, xfer;
        @(posedge clk);
        #1;
        reset = r; stall = st; branch_taken = br; branch_target = bt;
        jump = j; jump_target = jt; exception_req = ex; imem_ready = rdy;
        e.pc4 = 32'h0; e.ir = 32'h0; e.flush = 1'b1; e.tag = tag;
        if (r) begin
            e.req = 1'b0; e.addr = 32'h0;
            m_pc = RESET_PC; m_buf = 0; m_stale = 0; m_last_pc4 = 0; m_last_ir = 0;
        end else begin
            cur    = m_stale ? m_stale_addr : m_pc;
            e.req  = !m_buf;
            e.addr = cur;
            xfer   = e.req && rdy;
            redir  = (ex && EXC_ON) || br || j;
            tgt    = (ex && EXC_ON) ? EXC_VECTOR : (br ? bt : jt);
            if (redir) begin
                if (e.req && !rdy) begin
                    m_stale_addr = cur;
                    m_stale = 1;
                end else begin
                    m_stale = 0;
                end
                m_buf = 0;
                m_pc  = tgt;
            end else if (st) begin
                e.pc4 = m_last_pc4; e.ir = m_last_ir; e.flush = 1'b0;
                if (xfer) begin
                    if (m_stale) m_stale = 0;
                    else         m_buf = 1;
                end
            end else if (m_buf || (xfer && !m_stale)) begin
                e.pc4 = m_pc + 32'd4; e.ir = mem_word(m_pc); e.flush = 1'b0;
                m_last_pc4 = e.pc4; m_last_ir = e.ir;
                m_pc = m_pc + 32'd4;
                m_buf = 0;
            end else if (xfer) begin
                m_stale = 0;
            end
        end
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({PC_plus_4, IR, IF_ID_flush} !== {e.pc4, e.ir, e.flush}) begin
                n_bad++;
                $display("FAIL %s/ifid: got pc4=%h ir=%h flush=%b want pc4=%h ir=%h flush=%b",
                         e.tag, PC_plus_4, IR, IF_ID_flush, e.pc4, e.ir, e.flush);
            end
            n_cmp++;
            if (imem_req !== e.req) begin
                n_bad++;
                $display("FAIL %s/imem_req: got %b want %b", e.tag, imem_req, e.req);
            end
            if (e.req) begin
                n_cmp++;
                if (imem_addr !== e.addr) begin
                    n_bad++;
                    $display("FAIL %s/imem_addr: got %h want %h", e.tag, imem_addr, e.addr);
                end
            end
        end
    end

    initial begin
        logic [31:0] t1, t2;
        reset = 1; stall = 0; branch_taken = 0; jump = 0; exception_req = 0;
        imem_ready = 0; branch_target = 0; jump_target = 0;

        // Reset, then zero-wait first fetch at RESET_PC and the following one at 4.
        cycle(1, 0, 0, 0, 0, 0, 0, 1, "reset");
        cycle(1, 0, 0, 0, 0, 0, 0, 1, "reset");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "first");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "second");
        // Three wait states, then delivery.
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, "wait");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "after_wait");
        // Stall while the next fetch returns, then the held instruction once.
        cycle(0, 1, 0, 0, 0, 0, 0, 1, "stall_cap");
        cycle(0, 1, 0, 0, 0, 0, 0, 1, "stall_hold");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "hold_deliver");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "post_hold");
        // Branch with a fetch outstanding: stale response discarded, then 0x100.
        cycle(0, 0, 1, 32'h100, 0, 0, 0, 0, "br_outst");
        cycle(0, 0, 0, 0, 0, 0, 0, 0, "drop_wait");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "drop_xfer");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "at_100");
        // All three redirects together.
        cycle(0, 0, 1, 32'h200, 1, 32'h300, 1, 1, "prio");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "prio_next");
        // Wrap-around of pc+4.
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, "wrap_jmp");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "wrap_a");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "wrap_b");
        // Reset while dropping.
        cycle(0, 0, 1, 32'h400, 0, 0, 0, 0, "br_drop");
        cycle(1, 0, 0, 0, 0, 0, 0, 0, "rst_drop");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "rst_drop_rel");
        // Reset while holding.
        cycle(0, 1, 0, 0, 0, 0, 0, 1, "to_hold");
        cycle(1, 1, 0, 0, 0, 0, 0, 1, "rst_hold");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "rst_hold_rel");

        for (int i = 0; i < 3000; i++) begin
            t1 = $urandom() & 32'hFFFF_FFFC;
            t2 = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 8, t1, $urandom_range(0, 99) < 8, t2,
                  $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 60, "rand");
        end

        @(posedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
